// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and SLB requests onto the
// 8-bit RAM/IO bus, splits 1/2/4-byte accesses into byte beats and
// reassembles little-endian read data. I/O stores honour UART back-pressure.
module mem_ctrl #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        slb_req,
    input  logic        slb_wr,
    input  logic [1:0]  slb_len,
    input  logic [31:0] slb_addr,
    input  logic [31:0] slb_wdata,
    output logic        slb_done,
    output logic [31:0] slb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;          // 1 = SLB, 0 = fetch
    logic [2:0]  len_q, len_d;
    logic [2:0]  ic_q, ic_d;
    logic [2:0]  rc_q, rc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    // Which byte index the bus address of the previous cycle belonged to, so
    // mem_din is only captured when it really carries the byte we expect.
    logic        last_vld_q, last_vld_d;
    logic [2:0]  last_idx_q, last_idx_d;
    logic        io_wr_last_q, io_wr_last_d;
    logic        if_done_q, if_done_d;
    logic        slb_done_q, slb_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] slb_rdata_q, slb_rdata_d;

    logic        io_store, slb_ok, can_acc, cap, acc_wr;
    logic [2:0]  rc_n, acc_len;
    logic [31:0] acc_addr, acc_wdata;

    // Arbitration: SLB first unless it is an I/O store that must wait.
    always_comb begin
        io_store = slb_wr && (slb_addr[17:16] == IO_SEL);
        slb_ok   = slb_req && !(io_store && (io_buffer_full || io_wr_last_q));
        can_acc  = rst_n_in && rdy_in && !flush_in && !if_done_q && !slb_done_q;
        if (slb_ok) begin
            acc_addr  = slb_addr;
            acc_wdata = slb_wdata;
            acc_wr    = slb_wr;
            if (io_store || slb_len == 2'b00) acc_len = 3'd1;
            else if (slb_len == 2'b01)        acc_len = 3'd2;
            else                              acc_len = 3'd4;
        end else begin
            acc_addr  = if_addr;
            acc_wdata = '0;
            acc_wr    = 1'b0;
            acc_len   = 3'd4;
        end
    end

    // Next-state, beat issue/capture and bus drive.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        len_d       = len_q;
        ic_d        = ic_q;
        rc_d        = rc_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        if_data_d   = if_data_q;
        slb_rdata_d = slb_rdata_q;
        if_done_d   = 1'b0;
        slb_done_d  = 1'b0;
        last_vld_d  = 1'b0;
        last_idx_d  = last_idx_q;
        cap         = 1'b0;
        rc_n        = rc_q;
        mem_a       = '0;
        mem_dout    = '0;
        mem_wr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (can_acc && (slb_ok || if_req)) begin
                    owner_d = slb_ok;
                    addr_d  = acc_addr;
                    wdata_d = acc_wdata;
                    len_d   = acc_len;
                    ic_d    = 3'd1;
                    rc_d    = '0;
                    rbuf_d  = '0;
                    mem_a   = acc_addr;
                    if (acc_wr) begin
                        mem_wr   = 1'b1;
                        mem_dout = acc_wdata[7:0];
                        if (acc_len == 3'd1) begin
                            slb_done_d = 1'b1;
                            ic_d       = '0;
                        end else begin
                            state_d = WRITE;
                        end
                    end else begin
                        last_vld_d = 1'b1;
                        last_idx_d = '0;
                        state_d    = READ;
                    end
                end
            end
            READ: begin
                if (!rdy_in) begin
                    // Frozen: keep the bus on the next byte still owed so its
                    // data is waiting on mem_din when rdy_in returns.
                    mem_a      = addr_q + {29'd0, rc_q};
                    last_vld_d = 1'b1;
                    last_idx_d = rc_q;
                end else if (flush_in) begin
                    state_d = IDLE;
                    ic_d    = '0;
                    rc_d    = '0;
                end else begin
                    cap  = last_vld_q && (last_idx_q == rc_q);
                    rc_n = rc_q + {2'd0, cap};
                    rc_d = rc_n;
                    if (cap) rbuf_d[{rc_q[1:0], 3'b000} +: 8] = mem_din;
                    if (rc_n == len_q) begin
                        if (owner_q) begin
                            slb_done_d  = 1'b1;
                            slb_rdata_d = rbuf_d;
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = rbuf_d;
                        end
                        state_d = IDLE;
                        ic_d    = '0;
                        rc_d    = '0;
                    end else begin
                        mem_a      = addr_q + {29'd0, rc_n};
                        last_vld_d = 1'b1;
                        last_idx_d = rc_n;
                        ic_d       = rc_n + 3'd1;
                    end
                end
            end
            WRITE: begin
                // Stores are committed: flush is deliberately ignored here.
                mem_a    = addr_q + {29'd0, ic_q};
                mem_dout = wdata_q[{ic_q[1:0], 3'b000} +: 8];
                mem_wr   = rdy_in;
                if (rdy_in) begin
                    if (ic_q == len_q - 3'd1) begin
                        slb_done_d = 1'b1;
                        state_d    = IDLE;
                        ic_d       = '0;
                    end else begin
                        ic_d = ic_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        io_wr_last_d = mem_wr && (mem_a[17:16] == IO_SEL);
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            len_q        <= '0;
            ic_q         <= '0;
            rc_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            last_vld_q   <= 1'b0;
            last_idx_q   <= '0;
            io_wr_last_q <= 1'b0;
            if_done_q    <= 1'b0;
            slb_done_q   <= 1'b0;
            if_data_q    <= '0;
            slb_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            len_q        <= len_d;
            ic_q         <= ic_d;
            rc_q         <= rc_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            last_vld_q   <= last_vld_d;
            last_idx_q   <= last_idx_d;
            io_wr_last_q <= io_wr_last_d;
            if_done_q    <= if_done_d;
            slb_done_q   <= slb_done_d;
            if_data_q    <= if_data_d;
            slb_rdata_q  <= slb_rdata_d;
        end
    end

    assign if_done   = if_done_q;
    assign slb_done  = slb_done_q;
    assign if_data   = if_data_q;
    assign slb_rdata = slb_rdata_q;
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the CPU's two memory clients (instruction fetch and the store/load buffer) and the 8-bit RAM/IO bus. Arbitrates one transaction at a time, serialises 1/2/4-byte reads and writes into byte beats, reassembles little-endian read data, and enforces the UART back-pressure rule for I/O stores. It sits directly downstream of the fetch and SLB request ports and drives `mem_a`/`mem_dout`/`mem_wr` of the top level.

## Interface
- `IO_SEL`, default 2'b11: value of `addr[17:16]` that marks an I/O access.
- `clk_in`  in  1  single clock, all state on rising edge.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  global enable; low freezes all state.
- `flush_in`  in  1  control hazard; aborts reads.
- `io_buffer_full`  in  1  UART TX buffer full.
- `if_req`  in  1  fetch request, level, held until `if_done`.
- `if_addr`  in  32  fetch address (4-byte read).
- `if_done`  out  1  one-cycle pulse, `if_data` valid.
- `if_data`  out  32  fetched word.
- `slb_req`  in  1  SLB request, level, held until `slb_done`.
- `slb_wr`  in  1  1 = store, 0 = load.
- `slb_len`  in  2  00 byte, 01 half, 10 word (11 treated as word).
- `slb_addr`  in  32  byte address.
- `slb_wdata`  in  32  store data, byte 0 = bits [7:0].
- `slb_done`  out  1  one-cycle pulse; load data valid / store finished.
- `slb_rdata`  out  32  load data, zero-extended (SLB sign-extends).
- `mem_din`  in  8  RAM/IO read byte, valid the cycle after its address.
- `mem_dout`  out  8  write byte.
- `mem_a`  out  32  byte address.
- `mem_wr`  out  1  write strobe.

## Operation
- States: IDLE, READ, WRITE. Owner flag (IF/SLB), length N (1/2/4), issue counter `ic`, receive counter `rc` (0..4).
- Acceptance (IDLE only, rdy_in high, flush_in low, neither done pulse high this cycle): SLB wins over IF. IF is accepted if SLB is absent or blocked.
- I/O store block: SLB store with `slb_addr[17:16]==IO_SEL` is not accepted while `io_buffer_full` is high, nor in the cycle right after an I/O write beat. I/O stores are 1 byte.
- On accept, byte 0 is driven in the same cycle (`mem_a=addr`, `mem_wr`/`mem_dout` for stores). `ic=1`. State becomes READ/WRITE.
- READ: each cycle while `ic<N`, drive `addr+ic`, `ic++`. Each edge after a beat, capture `mem_din` into byte `rc`, `rc++`. When `rc` reaches N, pulse owner's done, load data register, return IDLE.
- WRITE: drive `addr+ic`, `slb_wdata` byte `ic`, `mem_wr=1`, `ic++`. After beat N-1, pulse `slb_done`, return IDLE.
- Address add is 32-bit modulo 2^32. Unread bytes of `slb_rdata` are 0.
- Flush in READ (either owner): abort, IDLE next cycle, no done pulse, data register unchanged. Flush never aborts WRITE, because stores are committed. A flush in IDLE blocks acceptance that cycle.
- `rdy_in` low: state, counters, and data hold. `mem_wr` is forced 0. The beat is replayed when `rdy_in` returns.
- Reset: state IDLE, counters 0, `if_done`=`slb_done`=0, `if_data`=`slb_rdata`=0, `mem_a`=0, `mem_dout`=0, `mem_wr`=0.

## Timing
- Request seen in cycle 0 (accepted). Read done pulse in cycle N+1: byte read cycle 2, half cycle 3, word cycle 5.
- Write done pulse in cycle N: byte cycle 1, word cycle 4. Byte beats occupy cycles 0..N-1.
- Done cycle is a 1-cycle bubble with no acceptance. The next transaction can start in cycle N+2 (read) / N+1 (write).
- `mem_a`, `mem_dout`, `mem_wr` are 0 in IDLE with no acceptance, and during read-wait cycles (`ic==N`, `rc<N`).
- Done pulses are registered and last exactly 1 cycle. Data outputs hold until the next done of the same owner.

## Test plan
- IF word read at 0x100, RAM holds 13 05 00 00 → `mem_a` 0x100..0x103 in cycles 0..3; `if_done` in cycle 5; `if_data`=0x00000513.
- `if_req` and `slb_req` (load half at 0x2002, bytes 34 12) rise together → SLB served first, `slb_rdata`=0x00001234 in cycle 3. IF is accepted in cycle 4 and `if_done` pulses in cycle 9.
- SLB byte store 0x41 to 0x30000 with `io_buffer_full`=1 for 3 cycles → no beat. Then single beat with `mem_wr`=1, `mem_dout`=0x41. A second I/O store is not accepted in the following cycle.
- IF word read, `flush_in` in cycle 2 → no `if_done`, IDLE in cycle 3, `if_data` unchanged. Store word 0xDEADBEEF to 0x40 with flush in cycle 1 → beats EF BE AD DE at 0x40..0x43, `slb_done` in cycle 4.
- `rdy_in` low for cycles 2-3 during a word read → `mem_wr`=0, beat 2 held. Data is still 4 correct bytes, and done is delayed by 2 cycles.
- `rst_n_in` low mid-WRITE (asynchronous) → all outputs 0 immediately; after release, the first request is accepted normally.
